// File: rtl/uart_rx_if.sv
// uart_rx serial input, byte holding register and status flags.
// master is the receiver side, slave is the line driver / consumer side.
`timescale 1ns/1ps
interface uart_rx_if;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        input  rx, rx_ack,
        output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        output rx, rx_ack,
        input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and valid/ack holding register.
// Optional UART_RX_GLITCH_FILTER_EN adds a 2-of-3 majority filter on the line.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_SPEED = 12000000,
    parameter int BAUD_RATE = 19200
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_if.master   bus
);
    localparam int BAUD_COUNT = CLK_SPEED / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CW = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_COUNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic sync1, sync2, line, prev, fall;

`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int WARM = 5;
    logic flt1, flt2, vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sync1, sync2, flt1, flt2, vote} <= '1;
        end else begin
            sync1 <= bus.rx;
            sync2 <= sync1;
            flt1  <= sync2;
            flt2  <= flt1;
            vote  <= (sync2 & flt1) | (sync2 & flt2) | (flt1 & flt2);
        end
    end

    assign line = vote;
`else
    localparam int WARM = 3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            sync2 <= sync1;
        end
    end

    assign line = sync2;
`endif

    // Edge detect stays disarmed until the pipeline holds real line samples,
    // so a line already low at reset release never looks like a start.
    logic [WARM-1:0] warm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm <= '0;
            prev <= 1'b0;
        end else begin
            warm <= {warm[WARM-2:0], 1'b1};
            prev <= warm[WARM-1] & line;
        end
    end

    assign fall = prev & ~line;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     bidx, bidx_n;
    logic           shift_en, stop_hit;
    logic [7:0]     shreg, data;
    logic           valid, ferr, ovr;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        bidx_n   = bidx;
        shift_en = 1'b0;
        stop_hit = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) state_n = START;
            end
            START: if (cnt == HALF_LAST) begin
                cnt_n   = '0;
                bidx_n  = '0;
                state_n = line ? IDLE : DATA;
            end
            DATA: if (cnt == FULL_LAST) begin
                cnt_n    = '0;
                shift_en = 1'b1;
                bidx_n   = bidx + 1'b1;
                if (bidx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == FULL_LAST) begin
                cnt_n    = '0;
                stop_hit = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            data  <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
            if (shift_en) shreg <= {line, shreg[7:1]};
            if (stop_hit && line) begin
                data  <= shreg;
                valid <= 1'b1;
                ovr   <= valid & ~bus.rx_ack;
            end else begin
                if (stop_hit) ferr <= 1'b1;
                if (bus.rx_ack) valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data      = data;
    assign bus.rx_valid     = valid;
    assign bus.rx_frame_err = ferr;
    assign bus.rx_overrun   = ovr;
    assign bus.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, corner sequences,
// and random traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CLK_SPEED = 1600;
    localparam int BAUD_RATE = 100;
    localparam int BC = 16;
    localparam int HC = 8;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int LAG = 4;
`else
    localparam int LAG = 2;
`endif
    localparam int NH = 8192;
    localparam int STOPOFS = HC + 9 * BC;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    uart_rx_if bus();

    uart_rx #(.CLK_SPEED(CLK_SPEED), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_at = -1;
    bit auto_ack = 1'b0;

    logic       hist[NH];
    logic       vh[NH], eh[NH], oh[NH], bh[NH];
    logic [7:0] dh[NH];

    typedef struct {
        logic [7:0] d;
        logic       stop_ok;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         c;
        int         kind;
        logic [7:0] d;
    } ev_t;

    vec_t tv[6];
    ev_t  mq[$];
    ev_t  dq[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(logic v);
        bus.rx = v;
        hist[cyc] = v;
        bus.rx_ack = (cyc == ack_at) || (auto_ack && bus.rx_valid === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NH) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NH);
            $fatal(1, "cycle budget exhausted");
        end
        vh[cyc] = bus.rx_valid;
        eh[cyc] = bus.rx_frame_err;
        oh[cyc] = bus.rx_overrun;
        bh[cyc] = bus.rx_busy;
        dh[cyc] = bus.rx_data;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1);
    endtask

    task automatic send_frame(logic [7:0] d, logic stop_ok);
        repeat (BC) step(1'b0);
        for (int k = 0; k < 8; k++) repeat (BC) step(d[k]);
        repeat (BC) step(stop_ok);
    endtask

    function automatic int rises(int a, int b);
        int n = 0;
        for (int c = a + 1; c <= b; c++) if (vh[c] && !vh[c-1]) n++;
        return n;
    endfunction

    function automatic int errs(int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (eh[c]) n++;
        return n;
    endfunction

    function automatic int ovrs(int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (oh[c]) n++;
        return n;
    endfunction

    function automatic logic any_busy(int a, int b);
        logic r = 1'b0;
        for (int c = a; c <= b; c++) r = r | bh[c];
        return r;
    endfunction

    // Reference view of the line: rx delayed, optionally majority-voted.
    function automatic logic rxv(int i);
        return (i < 0) ? 1'b1 : hist[i];
    endfunction

    function automatic logic ln(int t);
`ifdef UART_RX_GLITCH_FILTER_EN
        logic a = rxv(t - 3);
        logic b = rxv(t - 4);
        logic c = rxv(t - 5);
        return (a & b) | (a & c) | (b & c);
`else
        return rxv(t - 2);
`endif
    endfunction

    task automatic model(int endc);
        int t = 1;
        int d;
        logic [7:0] by;
        ev_t e;
        while (t <= endc) begin
            if (!ln(t) && ln(t - 1)) begin
                d = t;
                if (ln(d + HC)) begin
                    t = d + HC + 1;
                end else begin
                    if (d + STOPOFS + 1 <= endc) begin
                        for (int k = 0; k < 8; k++) by[k] = ln(d + HC + BC * (k + 1));
                        e.c = d + STOPOFS + 1;
                        e.kind = ln(d + STOPOFS) ? 0 : 1;
                        e.d = ln(d + STOPOFS) ? by : 8'h00;
                        mq.push_back(e);
                    end
                    t = d + STOPOFS + 1;
                end
            end else begin
                t++;
            end
        end
    endtask

    initial begin
        int c0, c1, c2, d, t, endc, n;
        ev_t e;

        tv[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        tv[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
        tv[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        tv[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hFF};
        tv[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};

        bus.rx = 1'b1;
        bus.rx_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_data", bus.rx_data, 8'h00);
        chk("reset_valid", bus.rx_valid, 1'b0);
        chk("reset_ferr", bus.rx_frame_err, 1'b0);
        chk("reset_ovr", bus.rx_overrun, 1'b0);
        chk("reset_busy", bus.rx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        vh[0] = 1'b0;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            c0 = cyc;
            send_frame(tv[i].d, tv[i].stop_ok);
            idle(6);
            d = c0 + LAG;
            t = d + STOPOFS + 1;
            chk("busy_rise", {bh[d], bh[d+1]}, 2'b01);
            chk("valid_before", vh[t-1], 1'b0);
            chk("valid", vh[t], tv[i].exp_valid);
            chk("ferr", eh[t], tv[i].exp_err);
            chk("ferr_width", eh[t+1], 1'b0);
            chk("ovr", oh[t], 1'b0);
            chk("data", dh[t], tv[i].exp_data);
            chk("busy_fall", {bh[t-1], bh[t]}, 2'b10);
            if (tv[i].exp_valid) begin
                ack_at = cyc;
                step(1'b1);
                ack_at = -1;
                chk("ack_clears", vh[cyc], 1'b0);
            end
        end

        // short low pulse: false start
        c0 = cyc;
        repeat (5) step(1'b0);
        idle(30);
        d = c0 + LAG;
        chk("fs_busy_rise", {bh[d], bh[d+1]}, 2'b01);
        chk("fs_idle_at_half", {bh[d+HC], bh[d+HC+1]}, 2'b10);
        chk("fs_no_err", errs(c0, cyc), 0);
        chk("fs_no_valid", rises(c0, cyc), 0);

        // single-cycle glitch
        c0 = cyc;
        step(1'b0);
        idle(30);
`ifdef UART_RX_GLITCH_FILTER_EN
        chk("glitch_filtered", any_busy(c0, cyc), 1'b0);
`else
        d = c0 + LAG;
        chk("glitch_start", bh[d+1], 1'b1);
        chk("glitch_false_start", {bh[d+HC], bh[d+HC+1]}, 2'b10);
        chk("glitch_no_err", errs(c0, cyc), 0);
`endif

        // overrun, then load coinciding with ack
        c0 = cyc;
        send_frame(8'h11, 1'b1);
        idle(3);
        c1 = cyc;
        send_frame(8'h22, 1'b1);
        idle(6);
        t = c1 + LAG + STOPOFS + 1;
        chk("first_valid", vh[c0+LAG+STOPOFS+1], 1'b1);
        chk("ovr_pulse", oh[t], 1'b1);
        chk("ovr_count", ovrs(c0, cyc), 1);
        chk("ovr_data", dh[t], 8'h22);
        chk("ovr_valid", vh[t], 1'b1);
        c2 = cyc;
        ack_at = c2 + LAG + STOPOFS;
        send_frame(8'h33, 1'b1);
        idle(6);
        ack_at = -1;
        t = c2 + LAG + STOPOFS + 1;
        chk("ack_same_valid", vh[t], 1'b1);
        chk("ack_same_data", dh[t], 8'h33);
        chk("ack_same_no_ovr", ovrs(c2, cyc), 0);

        // reset during data bit 4 of 0xFF, line held low across release
        repeat (BC) step(1'b0);
        repeat (4 * BC + 8) step(1'b1);
        chk("mid_frame_busy", bh[cyc], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", bus.rx_busy, 1'b0);
        chk("async_valid", bus.rx_valid, 1'b0);
        chk("async_data", bus.rx_data, 8'h00);
        repeat (3) step(1'b0);
        rst_n = 1'b1;
        c1 = cyc;
        repeat (12) step(1'b0);
        idle(6);
        chk("low_release_idle", any_busy(c1 + 1, cyc), 1'b0);
        c2 = cyc;
        send_frame(8'h5A, 1'b1);
        idle(6);
        t = c2 + LAG + STOPOFS + 1;
        chk("post_reset_one_byte", rises(c1, cyc), 1);
        chk("post_reset_valid", vh[t], 1'b1);
        chk("post_reset_data", dh[t], 8'h5A);
        chk("post_reset_no_err", errs(c1, cyc), 0);

        // random traffic against the frame-level model
        rst_n = 1'b0;
        bus.rx = 1'b1;
        bus.rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        vh[0] = 1'b0;
        auto_ack = 1'b1;
        idle(12);
        for (int i = 0; i < 16; i++) begin
            if ($urandom % 6 == 0) begin
                repeat ($urandom_range(1, 6)) step(1'b0);
                idle($urandom_range(3, 10));
            end else begin
                send_frame(8'($urandom), ($urandom % 5) != 0);
                idle($urandom_range(0, 12));
            end
        end
        idle(200);
        auto_ack = 1'b0;
        endc = cyc;
        for (int c = 1; c <= endc; c++) begin
            if (vh[c] && !vh[c-1]) begin
                e.c = c; e.kind = 0; e.d = dh[c];
                dq.push_back(e);
            end
            if (eh[c]) begin
                e.c = c; e.kind = 1; e.d = 8'h00;
                dq.push_back(e);
            end
            if (oh[c]) begin
                e.c = c; e.kind = 2; e.d = 8'h00;
                dq.push_back(e);
            end
        end
        model(endc);
        chk("rand_event_count", dq.size(), mq.size());
        n = (dq.size() < mq.size()) ? dq.size() : mq.size();
        for (int i = 0; i < n; i++) begin
            chk("rand_event_cycle", dq[i].c, mq[i].c);
            chk("rand_event_kind", dq[i].kind, mq[i].kind);
            chk("rand_event_data", dq[i].d, mq[i].d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
